// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the asynchronous SRAM arbiter.
package sram_ctrl_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_t;

  // Wait counter must hold WAIT_CYCLES and never collapse to zero bits.
  function automatic int wait_cnt_w(input int wait_cycles);
    int w;
    w = $clog2(wait_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin winner selection with a registered last-grant pointer.
module rr_arbiter2 (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic grant_en,
  output logic grant_valid,
  output logic grant_sel,
  output logic last_grant
);

  always_comb begin
    grant_valid = req0 | req1;
    // Under contention the port that was not served last wins.
    if (req0 && req1) grant_sel = ~last_grant;
    else              grant_sel = req1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset)         last_grant <= 1'b1;
    else if (grant_en) last_grant <= grant_sel;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin two-port front end and strobe sequencer for the 1M x 16 async SRAM.
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        be0,
  input  logic [1:0]        be1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  import sram_ctrl_pkg::*;

  localparam int CW = wait_cnt_w(WAIT_CYCLES);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            lat_we;
  logic            lat_sel;

  logic            grant_valid;
  logic            grant_sel;
  logic            last_grant;
  logic            grant_en;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_be;

  assign grant_en = (state == IDLE) && grant_valid;

  rr_arbiter2 u_arb (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .grant_en    (grant_en),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel),
    .last_grant  (last_grant)
  );

  always_comb begin
    sel_we    = grant_sel ? we1    : we0;
    sel_addr  = grant_sel ? addr1  : addr0;
    sel_wdata = grant_sel ? wdata1 : wdata0;
    sel_be    = grant_sel ? be1    : be0;
  end

  // Strobes are launched from the winner's inputs on the grant edge so the
  // first ACCESS cycle already shows them; the latches cover later cycles.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_we      <= 1'b0;
      lat_sel     <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata       <= '0;
      SRAM_ADDR   <= '0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state     <= ACCESS;
            wait_cnt  <= CW'(WAIT_CYCLES);
            lat_we    <= sel_we;
            lat_sel   <= grant_sel;
            SRAM_ADDR <= sel_addr;
            SRAM_CE_N <= 1'b0;
            SRAM_OE_N <= sel_we;
            SRAM_WE_N <= ~sel_we;
            SRAM_LB_N <= ~sel_be[0];
            SRAM_UB_N <= ~sel_be[1];
            sram_dq_oe <= sel_we;
            if (sel_we) sram_dq_out <= sel_wdata;
          end
        end
        ACCESS: begin
          if (wait_cnt == '0) begin
            state     <= RECOVER;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            if (!lat_we) rdata <= sram_dq_in;
            if (lat_sel) ack1 <= 1'b1;
            else         ack0 <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        RECOVER: begin
          state      <= IDLE;
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          sram_dq_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one default build with an SRAM model and one WAIT_CYCLES=0 build.
module tb_sram_arbiter;

  import sram_ctrl_pkg::*;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        req0, req1, we0, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  be0, be1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  logic        req0_z, req1_z, we0_z, we1_z;
  logic [19:0] addr0_z, addr1_z;
  logic [15:0] wdata0_z, wdata1_z;
  logic [1:0]  be0_z, be1_z;
  logic        ack0_z, ack1_z;
  logic [15:0] rdata_z;
  logic [19:0] addr_z;
  logic        ce_n_z, oe_n_z, we_n_z, lb_n_z, ub_n_z;
  logic [15:0] dq_out_z;
  logic [15:0] dq_in_z = 16'hC35A;
  logic        dq_oe_z;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0)) dut_z (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .req0(req0_z), .req1(req1_z), .we0(we0_z), .we1(we1_z),
    .addr0(addr0_z), .addr1(addr1_z), .wdata0(wdata0_z), .wdata1(wdata1_z),
    .be0(be0_z), .be1(be1_z), .ack0(ack0_z), .ack1(ack1_z), .rdata(rdata_z),
    .SRAM_ADDR(addr_z), .SRAM_CE_N(ce_n_z), .SRAM_OE_N(oe_n_z),
    .SRAM_WE_N(we_n_z), .SRAM_LB_N(lb_n_z), .SRAM_UB_N(ub_n_z),
    .sram_dq_out(dq_out_z), .sram_dq_oe(dq_oe_z), .sram_dq_in(dq_in_z)
  );

  // Byte-laned SRAM model over the low 256 words.
  logic [15:0] mem [0:255];
  always @(posedge CLOCK_50) begin
    if (!SRAM_CE_N && !SRAM_WE_N && sram_dq_oe) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR[7:0]][7:0]  <= sram_dq_out[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR[7:0]][15:8] <= sram_dq_out[15:8];
    end
  end
  assign sram_dq_in = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  int          we_lo, oe_lo, dqoe_hi, overlap, ack0_n, ack1_n, ack0_cyc, ack1_cyc;
  logic [15:0] rd0, rd1;
  logic        lb_seen, ub_seen;

  task automatic post(input int port, input logic we, input logic [19:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    if (port == 0) begin
      we0 = we; addr0 = a; wdata0 = d; be0 = be; req0 = 1'b1;
    end else begin
      we1 = we; addr1 = a; wdata1 = d; be1 = be; req1 = 1'b1;
    end
  endtask

  // Samples n cycles after the request cycle (cycle 0); a requester drops req on its ack.
  task automatic observe(input int n);
    we_lo = 0; oe_lo = 0; dqoe_hi = 0; overlap = 0;
    ack0_n = 0; ack1_n = 0; ack0_cyc = -1; ack1_cyc = -1;
    rd0 = '0; rd1 = '0; lb_seen = 1'b1; ub_seen = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge CLOCK_50);
      if (!SRAM_WE_N) we_lo++;
      if (!SRAM_OE_N) oe_lo++;
      if (sram_dq_oe) dqoe_hi++;
      if (sram_dq_oe && !SRAM_OE_N) overlap++;
      if (!SRAM_CE_N) begin lb_seen = SRAM_LB_N; ub_seen = SRAM_UB_N; end
      if (ack0) begin ack0_n++; if (ack0_cyc < 0) ack0_cyc = c; rd0 = rdata; req0 = 1'b0; end
      if (ack1) begin ack1_n++; if (ack1_cyc < 0) ack1_cyc = c; rd1 = rdata; req1 = 1'b0; end
    end
  endtask

  initial begin
    int          oe_z;
    logic [9:0]  mask_z;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; be0 = 2'b11; be1 = 2'b11;
    req0_z = 0; req1_z = 0; we0_z = 0; we1_z = 0; addr0_z = '0; addr1_z = '0;
    wdata0_z = '0; wdata1_z = '0; be0_z = 2'b11; be1_z = 2'b11;
    repeat (3) @(negedge CLOCK_50);

    check("rst_strobes", {27'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N}, 32'h1F);
    check("rst_addr", {12'd0, SRAM_ADDR}, 32'h0);
    check("rst_dq", {15'd0, sram_dq_oe, sram_dq_out}, 32'h0);
    check("rst_ack_rdata", {14'd0, ack0, ack1, rdata}, 32'h0);
    check("rst_last_grant", {31'd0, dut.u_arb.last_grant}, 32'h1);

    reset = 1'b0;
    @(negedge CLOCK_50);

    // Single write from port 0.
    post(0, 1'b1, 20'h00005, 16'hBEEF, 2'b11);
    observe(6);
    check("wr_we_lo", we_lo, 2);
    check("wr_dqoe_hi", dqoe_hi, 3);
    check("wr_ack0_cyc", ack0_cyc, 3);
    check("wr_ack0_n", ack0_n, 1);
    check("wr_ack1_n", ack1_n, 0);
    check("wr_mem", {16'd0, mem[5]}, 32'hBEEF);

    // Read-back from port 1.
    post(1, 1'b0, 20'h00005, 16'h0000, 2'b11);
    observe(6);
    check("rd_rdata", {16'd0, rd1}, 32'hBEEF);
    check("rd_ack1_cyc", ack1_cyc, 3);
    check("rd_oe_lo", oe_lo, 2);
    check("rd_dqoe_hi", dqoe_hi, 0);
    check("rd_ack0_n", ack0_n, 0);
    check("rd_hold", {16'd0, rdata}, 32'hBEEF);

    // Lower-byte-only write.
    post(0, 1'b1, 20'h00005, 16'h12AB, 2'b01);
    observe(6);
    check("bl_lb_n", {31'd0, lb_seen}, 32'h0);
    check("bl_ub_n", {31'd0, ub_seen}, 32'h1);
    check("bl_ack0_cyc", ack0_cyc, 3);
    check("bl_mem", {16'd0, mem[5]}, 32'hBEAB);
    post(1, 1'b0, 20'h00005, 16'h0000, 2'b11);
    observe(6);
    check("bl_readback", {16'd0, rd1}, 32'hBEAB);

    // Contention straight after reset, then a second simultaneous pair.
    reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    for (int pair = 0; pair < 2; pair++) begin
      post(0, 1'b0, 20'h00005, 16'h0000, 2'b11);
      post(1, 1'b0, 20'h00005, 16'h0000, 2'b11);
      observe(10);
      check($sformatf("ct%0d_ack0_cyc", pair), ack0_cyc, 3);
      check($sformatf("ct%0d_ack1_cyc", pair), ack1_cyc, 7);
      check($sformatf("ct%0d_acks", pair), {ack0_n[15:0], ack1_n[15:0]}, 32'h0001_0001);
      check($sformatf("ct%0d_rd1", pair), {16'd0, rd1}, 32'hBEAB);
      check($sformatf("ct%0d_overlap", pair), overlap, 0);
    end

    // Reset during the first ACCESS cycle of a write.
    post(0, 1'b1, 20'h00009, 16'h5555, 2'b11);
    @(negedge CLOCK_50);
    check("rm_we_active", {31'd0, SRAM_WE_N}, 32'h0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("rm_strobes", {30'd0, SRAM_WE_N, SRAM_CE_N}, 32'h3);
    check("rm_dqoe_ack", {30'd0, sram_dq_oe, ack0}, 32'h0);
    check("rm_state", 32'(dut.state), 32'(IDLE));
    req0 = 1'b0;
    reset = 1'b0;
    @(negedge CLOCK_50);
    post(0, 1'b0, 20'h00005, 16'h0000, 2'b11);
    observe(6);
    check("rm_rd_ack0_cyc", ack0_cyc, 3);
    check("rm_rd_rdata", {16'd0, rd0}, 32'hBEAB);

    // WAIT_CYCLES=0 build: single read, then port 1 holding req back to back.
    we0_z = 1'b0; addr0_z = 20'h00010; req0_z = 1'b1;
    oe_z = 0; mask_z = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLOCK_50);
      if (!oe_n_z) oe_z++;
      if (ack0_z) begin mask_z[c] = 1'b1; req0_z = 1'b0; check("z_rdata", {16'd0, rdata_z}, 32'hC35A); end
    end
    check("z_ack_cyc", {22'd0, mask_z}, 32'h004);
    check("z_oe_lo", oe_z, 1);
    we1_z = 1'b0; addr1_z = 20'h00020; req1_z = 1'b1;
    mask_z = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLOCK_50);
      if (ack1_z) mask_z[c] = 1'b1;
      if (c == 8) req1_z = 1'b0;
    end
    check("z_b2b_acks", {22'd0, mask_z}, 32'h124);
    repeat (4) @(negedge CLOCK_50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and timing controller for the board's 1M x 16 asynchronous SRAM (20-bit address, 16-bit data, active-low CE/OE/WE/LB/UB).
- Port 0 is a host/loader requester and port 1 is a display/scanner requester (for example, an address-stepping HEX viewer).
- Each access is granted round-robin, the SRAM strobes are sequenced with a programmable access width, and a one-cycle ack is returned.
- Sits between the requesters and the SRAM pins. The top level owns the DQ tri-state buffer.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 1, number of extra cycles the strobes are held beyond one (strobe width = WAIT_CYCLES+1 clocks; 40 ns at 50 MHz).

Ports:
- CLOCK_50  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request; held high until matching ack
- we0 / we1  in  1  1=write, 0=read; stable while req is high
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- be0 / be1  in  2  byte enables, [1]=upper, [0]=lower; active-high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data; valid in the ack cycle of a read, held until the next read completes
- SRAM_ADDR  out  ADDR_W  address pins
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  out  1  strobes, active-low
- sram_dq_out  out  DATA_W  write data to the top-level tri-state
- sram_dq_oe  out  1  1 = top level drives SRAM_DQ
- sram_dq_in  in  DATA_W  SRAM_DQ as read back from the pins

Behaviour:
- All outputs are registered.
- Reset values:
  - CE_N, OE_N, WE_N, LB_N, UB_N = 1
  - SRAM_ADDR = 0
  - sram_dq_oe = 0, sram_dq_out = 0
  - ack0 = ack1 = 0
  - rdata = 0
  - last_grant = 1, so port 0 wins the first contention
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any req is high, choose a winner. With only one requester, that port wins. With both, the port not equal to last_grant wins.
  - Latch we/addr/wdata/be of the winner, update last_grant, load wait counter = WAIT_CYCLES, go to ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles):
  - CE_N=0; LB_N=~be[0], UB_N=~be[1]; SRAM_ADDR = latched address.
  - Read: OE_N=0, WE_N=1, dq_oe=0.
  - Write: OE_N=1, WE_N=0, dq_oe=1, dq_out = latched data.
  - The counter decrements each cycle. When it reaches 0, go to RECOVER.
  - For a read, rdata <= sram_dq_in on that transition edge.
- RECOVER (1 cycle):
  - WE_N=OE_N=1, CE_N=1, LB_N=UB_N=1.
  - dq_oe stays 1 for a write (data hold after the WE rising edge), then drops to 0 on exit.
  - Address is held.
  - Assert ack of the granted port for exactly this cycle. Go to IDLE.
- Latency: req first seen in IDLE at cycle 0 -> ack at cycle WAIT_CYCLES+2. Throughput: one access per WAIT_CYCLES+3 cycles.
- The requester must drop req, or present a new request, in the cycle after ack. A req still high in IDLE is a new request.
- be = 2'b00 is a legal no-op access: full timing and ack are produced, with LB_N=UB_N=1.
- A req that rises while another port is being served waits. It is guaranteed service next, by round-robin after that access.
- Requester inputs are ignored outside IDLE; the latched copies are used.
- Reset mid-operation: on the next edge all strobes go inactive, dq_oe=0, no ack is issued, the FSM returns to IDLE, last_grant=1. An aborted write may be partially written; this is accepted.
- dq_oe and OE_N are never both active. Any access has at least one cycle with dq_oe=0 before OE_N=0 (guaranteed by RECOVER+IDLE).
- WAIT_CYCLES=0 is legal: one strobe cycle.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum {IDLE, ACCESS, RECOVER}
  - localparams ADDR_W=20, DATA_W=16
  - width of the wait counter, $clog2(WAIT_CYCLES+1) with a minimum of 1
- Sub-module rr_arbiter2: combinational winner selection from req0, req1 and last_grant, plus the registered last_grant update on a grant enable.
- The FSM, datapath latches and strobe registers stay in sram_arbiter.

Test Plan:
- Single write: reset, then port0 writes addr=0x00005, wdata=0xBEEF, be=11.
  - WE_N is low for exactly 2 cycles and dq_oe is high for 3 cycles.
  - ack0 pulses at cycle 3; ack1 stays 0.
- Read-back: port1 reads addr 0x00005 while the SRAM model returns 0xBEEF.
  - rdata=0xBEEF in the ack1 cycle (cycle 3); OE_N is low 2 cycles; dq_oe=0 throughout.
- Contention: req0 and req1 rise in the same cycle after reset.
  - Port0 is served first (ack0 at cycle 3), then port1 (ack1 at cycle 7).
  - A second simultaneous pair gives port0, then port1 again.
- Byte lane: port0 writes 0x12AB with be=01.
  - LB_N=0 and UB_N=1 during ACCESS; the model keeps its upper byte unchanged.
- Reset mid-write: reset is asserted in the first ACCESS cycle of a write.
  - The next cycle shows WE_N=1, CE_N=1, dq_oe=0, no ack, state IDLE.
  - Afterwards, a port0 read completes normally.
- WAIT_CYCLES=0 build: a read is acked at cycle 2 with OE_N low for 1 cycle. A back-to-back read from port1 holding req is acked every 3 cycles.
